// File: rtl/int_to_fp_round_pack_pkg.sv
// Shared constants and bundles for the integer-to-FP32 round/pack path.
// Rounding-mode encodings, FP32 field geometry, fflags bit positions.
package int_to_fp_round_pack_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [EXP_W-1:0] FP32_BIAS = 8'd127;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  // Fill value for the upper FLEN-32 bits of a boxed single.
  localparam logic NANBOX_FILL = 1'b1;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [5:0]        exp;
    logic [MANT_W-1:0] mant;
    logic              inc;
    logic              nx;
    logic              rm_err;
  } s1_t;

endpackage

// File: rtl/int_to_fp_round_pack_if.sv
// Upstream and downstream valid/ready bundle for the round/pack stage.
// master = producer/consumer side, slave = the stage itself.
interface int_to_fp_round_pack_if #(
  parameter int FLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic             in_zero;
  logic [5:0]       in_exp;
  logic [63:0]      in_mag;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [FLEN-1:0]  out_data;
  logic [4:0]       out_fflags;
  logic             out_rm_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_sign, in_zero, in_exp,
    output in_mag, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_fflags, out_rm_err, out_tag
  );

  modport slave (
    input  in_valid, in_sign, in_zero, in_exp,
    input  in_mag, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_data,
    output out_fflags, out_rm_err, out_tag
  );
endinterface

// File: rtl/fp32_round_inc.sv
// Round-increment decision from rm, sign, lsb, guard and sticky.
// Reserved rm values round as RNE and raise rm_err.
module fp32_round_inc
  import int_to_fp_round_pack_pkg::*;
(
  input  logic [2:0] i_rm,
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic       i_g,
  input  logic       i_s,
  output logic       o_inc,
  output logic       o_rm_err
);

  // Per-mode increment select.
  always_comb begin
    o_inc    = 1'b0;
    o_rm_err = 1'b0;
    case (i_rm)
      RM_RNE: o_inc = i_g & (i_s | i_lsb);
      RM_RTZ: o_inc = 1'b0;
      RM_RDN: o_inc = i_sign & (i_g | i_s);
      RM_RUP: o_inc = ~i_sign & (i_g | i_s);
      RM_RMM: o_inc = i_g;
      default: begin
        o_inc    = i_g & (i_s | i_lsb);
        o_rm_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/int_to_fp_round_pack.sv
// Two-stage round/pack of a normalised integer into a NaN-boxed FP32.
// Stage 1 decides the increment, stage 2 adds it and packs the fields.
module int_to_fp_round_pack
  import int_to_fp_round_pack_pkg::*;
#(
  parameter int FLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  int_to_fp_round_pack_if.slave bus
);

  logic             r_s1_valid;
  s1_t              r_s1;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic [FLEN-1:0]  r_out_data;
  logic [4:0]       r_out_fflags;
  logic             r_out_rm_err;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_s2_load;
  logic             w_s1_adv;
  logic             w_s2_fill;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_sticky;
  logic             w_inc;
  logic             w_rm_err;
  s1_t              w_s1_d;
  logic [MANT_W:0]  w_sum;
  logic [EXP_W-1:0] w_expf;
  logic [MANT_W-1:0] w_frac;
  logic [31:0]      w_field;
  logic [4:0]       w_ff;
  logic             w_unused;

  assign w_s2_load  = ~r_s2_valid | bus.out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_load;
  assign w_s2_fill  = w_s1_adv & ~flush;
  assign w_in_ready = ~flush & (~r_s1_valid | w_s2_load);
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_sticky   = |bus.in_mag[38:0];
  assign w_unused   = bus.in_mag[63];

  fp32_round_inc u_round_inc (
    .i_rm     (bus.in_rm),
    .i_sign   (bus.in_sign),
    .i_lsb    (bus.in_mag[40]),
    .i_g      (bus.in_mag[39]),
    .i_s      (w_sticky),
    .o_inc    (w_inc),
    .o_rm_err (w_rm_err)
  );

  // Stage 1 bundle built from the incoming beat.
  always_comb begin
    w_s1_d        = '0;
    w_s1_d.sign   = bus.in_sign;
    w_s1_d.zero   = bus.in_zero;
    w_s1_d.exp    = bus.in_exp;
    w_s1_d.mant   = bus.in_mag[62:40];
    w_s1_d.inc    = w_inc;
    w_s1_d.nx     = (bus.in_mag[39] | w_sticky) & ~bus.in_zero;
    w_s1_d.rm_err = w_rm_err;
  end

  // Stage 2 add, carry into exponent, and field pack.
  always_comb begin
    w_sum   = {1'b0, r_s1.mant} + {{MANT_W{1'b0}}, r_s1.inc};
    w_expf  = {2'b00, r_s1.exp} + FP32_BIAS
            + {{(EXP_W-1){1'b0}}, w_sum[MANT_W]};
    w_frac  = w_sum[MANT_W] ? '0 : w_sum[MANT_W-1:0];
    w_field = r_s1.zero ? 32'h0 : {r_s1.sign, w_expf, w_frac};
    // Exponent tops out at 191, so only NX can ever be raised.
    w_ff        = '0;
    w_ff[FF_NV] = 1'b0;
    w_ff[FF_DZ] = 1'b0;
    w_ff[FF_OF] = 1'b0;
    w_ff[FF_UF] = 1'b0;
    w_ff[FF_NX] = r_s1.nx & ~r_s1.zero;
  end

  // Stage 1 valid and capture of accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s1_tag   <= '0;
    end else begin
      if (flush)         r_s1_valid <= 1'b0;
      else if (w_acc)    r_s1_valid <= 1'b1;
      else if (w_s1_adv) r_s1_valid <= 1'b0;
      if (w_acc) begin
        r_s1     <= w_s1_d;
        r_s1_tag <= bus.in_tag;
      end
    end
  end

  // Stage 2 valid and registered outputs, held under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_out_data   <= '0;
      r_out_fflags <= '0;
      r_out_rm_err <= 1'b0;
      r_out_tag    <= '0;
    end else begin
      if (flush)          r_s2_valid <= 1'b0;
      else if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s2_fill) begin
        r_out_data   <= {{(FLEN-32){NANBOX_FILL}}, w_field};
        r_out_fflags <= w_ff;
        r_out_rm_err <= r_s1.rm_err;
        r_out_tag    <= r_s1_tag;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_fflags = r_out_fflags;
  assign bus.out_rm_err = r_out_rm_err;
  assign bus.out_tag    = r_out_tag;

endmodule

// File: tb/tb_int_to_fp_round_pack.sv
// Directed bench for int_to_fp_round_pack.
// Hand-computed FP32 results, handshake, flush and reset scenarios.
module tb_int_to_fp_round_pack;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_pass  = 0;
  int   n_total = 0;

  int_to_fp_round_pack_if #(.FLEN(64), .TAG_W(5)) bus ();

  int_to_fp_round_pack #(.FLEN(64), .TAG_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] bb_mag [4] = '{64'h8000_0000_0000_0000,
                              64'h8000_0000_0000_0000,
                              64'hC000_0000_0000_0000,
                              64'h8000_0000_0000_0000};
  logic [5:0]  bb_exp [4] = '{6'd0, 6'd1, 6'd1, 6'd2};
  logic [63:0] bb_dat [4] = '{64'hFFFF_FFFF_3F80_0000,
                              64'hFFFF_FFFF_4000_0000,
                              64'hFFFF_FFFF_4040_0000,
                              64'hFFFF_FFFF_4080_0000};

  task automatic drive(input logic s, input logic z,
                       input logic [5:0] e, input logic [63:0] m,
                       input logic [2:0] rm, input logic [4:0] t);
    bus.in_sign = s;
    bus.in_zero = z;
    bus.in_exp  = e;
    bus.in_mag  = m;
    bus.in_rm   = rm;
    bus.in_tag  = t;
  endtask

  // One beat through an empty pipe; lat counts edges from accept.
  task automatic run_one(input logic s, input logic z,
                         input logic [5:0] e, input logic [63:0] m,
                         input logic [2:0] rm, input logic [4:0] t,
                         output logic [63:0] d, output logic [4:0] ff,
                         output logic re, output logic [4:0] tg,
                         output int lat);
    @(negedge clk);
    drive(s, z, e, m, rm, t);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    d  = bus.out_data;
    ff = bus.out_fflags;
    re = bus.out_rm_err;
    tg = bus.out_tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 64'h0, 3'b000, 5'd0);
    #2;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.out_data !== 64'h0)
      $display("FAIL rst_data got %h want 0", bus.out_data);
    else n_pass++;
    n_total++;
    if (bus.out_fflags !== 5'h0 || bus.out_tag !== 5'h0 || bus.out_rm_err !== 1'b0)
      $display("FAIL rst_flags got %h/%h/%b want 0/0/0",
               bus.out_fflags, bus.out_tag, bus.out_rm_err);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_int_one();
    logic [63:0] d; logic [4:0] ff, tg; logic re; int lat;
    run_one(1'b0, 1'b0, 6'd0, 64'h8000_0000_0000_0000, 3'b000, 5'd1,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_3F80_0000)
      $display("FAIL int1_data got %h want ffffffff3f800000", d);
    else n_pass++;
    n_total++;
    if (ff !== 5'b00000) $display("FAIL int1_fflags got %b want 00000", ff);
    else n_pass++;
    n_total++;
    if (lat !== 2) $display("FAIL int1_latency got %0d want 2", lat);
    else n_pass++;
    n_total++;
    if (tg !== 5'd1 || re !== 1'b0)
      $display("FAIL int1_tag got %0d/%b want 1/0", tg, re);
    else n_pass++;
  endtask

  task automatic test_round_2p24();
    logic [63:0] d; logic [4:0] ff, tg; logic re; int lat;
    run_one(1'b0, 1'b0, 6'd24, 64'h8000_0080_0000_0000, 3'b000, 5'd2,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_4B80_0000 || ff !== 5'b00001)
      $display("FAIL p24_rne got %h/%b want ffffffff4b800000/00001", d, ff);
    else n_pass++;
    run_one(1'b0, 1'b0, 6'd24, 64'h8000_0080_0000_0000, 3'b011, 5'd3,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_4B80_0001 || ff !== 5'b00001)
      $display("FAIL p24_rup got %h/%b want ffffffff4b800001/00001", d, ff);
    else n_pass++;
    run_one(1'b1, 1'b0, 6'd24, 64'h8000_0080_0000_0000, 3'b010, 5'd4,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_CB80_0001 || ff !== 5'b00001)
      $display("FAIL p24_rdn_neg got %h/%b want ffffffffcb800001/00001", d, ff);
    else n_pass++;
  endtask

  task automatic test_carry();
    logic [63:0] d; logic [4:0] ff, tg; logic re; int lat;
    run_one(1'b0, 1'b0, 6'd24, 64'hFFFF_FF80_0000_0000, 3'b000, 5'd5,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_4C00_0000 || ff !== 5'b00001)
      $display("FAIL carry_rne got %h/%b want ffffffff4c000000/00001", d, ff);
    else n_pass++;
    run_one(1'b0, 1'b0, 6'd24, 64'hFFFF_FF80_0000_0000, 3'b001, 5'd6,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_4BFF_FFFF || ff !== 5'b00001)
      $display("FAIL carry_rtz got %h/%b want ffffffff4bffffff/00001", d, ff);
    else n_pass++;
  endtask

  task automatic test_misc();
    logic [63:0] d; logic [4:0] ff, tg; logic re; int lat;
    run_one(1'b1, 1'b0, 6'd1, 64'hC000_0000_0000_0000, 3'b100, 5'd7,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_C040_0000 || ff !== 5'b00000)
      $display("FAIL neg3_rmm got %h/%b want ffffffffc0400000/00000", d, ff);
    else n_pass++;
    run_one(1'b1, 1'b1, 6'd0, 64'h0, 3'b000, 5'd8, d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_0000_0000 || ff !== 5'b00000)
      $display("FAIL zero got %h/%b want ffffffff00000000/00000", d, ff);
    else n_pass++;
    run_one(1'b0, 1'b0, 6'd24, 64'hFFFF_FF80_0000_0000, 3'b101, 5'd9,
            d, ff, re, tg, lat);
    n_total++;
    if (d !== 64'hFFFF_FFFF_4C00_0000 || ff !== 5'b00001)
      $display("FAIL rm101_data got %h/%b want ffffffff4c000000/00001", d, ff);
    else n_pass++;
    n_total++;
    if (re !== 1'b1 || tg !== 5'd9)
      $display("FAIL rm101_err got %b/%0d want 1/9", re, tg);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    int got = 0;
    int acc_early = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 4);
      if (nxt < 4) begin
        drive(1'b0, 1'b0, bb_exp[nxt], bb_mag[nxt], 3'b000, 5'(nxt + 1));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        n_total++;
        if (bus.in_ready !== 1'b0)
          $display("FAIL bp_in_ready got %b want 0", bus.in_ready);
        else n_pass++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        n_total++;
        if (bus.out_data !== bb_dat[0] || bus.out_tag !== 5'd1)
          $display("FAIL bp_hold got %h/%0d want %h/1",
                   bus.out_data, bus.out_tag, bb_dat[0]);
        else n_pass++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_total++;
        if (bus.out_tag !== 5'(got + 1))
          $display("FAIL bp_order got %0d want %0d", bus.out_tag, got + 1);
        else n_pass++;
        n_total++;
        if (bus.out_data !== bb_dat[got])
          $display("FAIL bp_data got %h want %h", bus.out_data, bb_dat[got]);
        else n_pass++;
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        if (cyc < 4) acc_early++;
        nxt++;
      end
    end
    bus.in_valid = 1'b0;
    n_total++;
    if (acc_early !== 2)
      $display("FAIL bp_accepts got %0d want 2", acc_early);
    else n_pass++;
    n_total++;
    if (got !== 4) $display("FAIL bp_count got %0d want 4", got);
    else n_pass++;
  endtask

  task automatic test_flush();
    int seen = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 64'h8000_0000_0000_0000, 3'b000, 5'd10);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 6'd1, 64'h8000_0000_0000_0000, 3'b000, 5'd11);
    @(negedge clk);
    drive(1'b0, 1'b0, 6'd1, 64'hC000_0000_0000_0000, 3'b000, 5'd7);
    flush = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL flush_in_ready got %b want 0", bus.in_ready);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL flush_state got v=%b r=%b want v=0 r=1",
               bus.out_valid, bus.in_ready);
    else n_pass++;
    n_total++;
    if (bus.out_data !== 64'hFFFF_FFFF_3F80_0000 || bus.out_tag !== 5'd10)
      $display("FAIL flush_keep got %h/%0d want ffffffff3f800000/10",
               bus.out_data, bus.out_tag);
    else n_pass++;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL flush_drop got %0d outputs want 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 6'd2, 64'h8000_0000_0000_0000, 3'b000, 5'd3);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b1)
      $display("FAIL rmid_pre got %b want 1", bus.out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0 || bus.out_tag !== 5'd0)
      $display("FAIL rmid_async got v=%b d=%h t=%0d want 0/0/0",
               bus.out_valid, bus.out_data, bus.out_tag);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL rmid_after got r=%b v=%b want 1/0",
               bus.in_ready, bus.out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_int_one();
    test_round_2p24();
    test_carry();
    test_misc();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
